// File: rtl/numbotron_pkg.sv
// Shared definitions for the counter-machine sequencer: opcodes, FSM states and
// instruction-word field extraction parameterised on register-index and pc widths.
package numbotron_pkg;

  localparam logic [1:0] OP_INC   = 2'd0;
  localparam logic [1:0] OP_DECJZ = 2'd1;
  localparam logic [1:0] OP_HALT  = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  typedef enum logic [1:0] {
    S_EDIT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // Instruction layout: {op[1:0], ridx[ridx_w], tgt_a[pc_w], tgt_b[pc_w]}
  function automatic int unsigned insn_w(input int unsigned ridx_w, input int unsigned pc_w);
    return 2 + ridx_w + 2 * pc_w;
  endfunction

  function automatic logic [31:0] field_mask(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] insn_op(input logic [31:0] insn, input int unsigned ridx_w,
                                          input int unsigned pc_w);
    return (insn >> (ridx_w + 2 * pc_w)) & 32'd3;
  endfunction

  function automatic logic [31:0] insn_ridx(input logic [31:0] insn, input int unsigned ridx_w,
                                            input int unsigned pc_w);
    return (insn >> (2 * pc_w)) & field_mask(ridx_w);
  endfunction

  function automatic logic [31:0] insn_tgt_a(input logic [31:0] insn, input int unsigned pc_w);
    return (insn >> pc_w) & field_mask(pc_w);
  endfunction

  function automatic logic [31:0] insn_tgt_b(input logic [31:0] insn, input int unsigned pc_w);
    return insn & field_mask(pc_w);
  endfunction

endpackage

// File: rtl/numbotron_button_edge.sv
// Step-button conditioning: two-flop synchroniser followed by a registered
// rising-edge detector producing a single-cycle pulse.
module numbotron_button_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/numbotron_sequencer.sv
// Minsky-style counter-machine thread: editable program RAM, preloadable counters,
// INC / DECJZ / HALT / NOP executed one per qualified tick or step press.
module numbotron_sequencer #(
  parameter  int unsigned NUM_REGS   = 8,
  parameter  int unsigned REG_W      = 8,
  parameter  int unsigned PROG_DEPTH = 32,
  parameter  bit          SATURATE   = 1'b0,
  localparam int unsigned RIDX_W     = $clog2(NUM_REGS),
  localparam int unsigned PC_W       = $clog2(PROG_DEPTH),
  localparam int unsigned INSN_W     = numbotron_pkg::insn_w(RIDX_W, PC_W)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                tick,
  input  logic                step_btn,
  input  logic [1:0]          mode,
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_addr,
  input  logic [INSN_W-1:0]   prog_data,
  input  logic                reg_we,
  input  logic [RIDX_W-1:0]   reg_widx,
  input  logic [REG_W-1:0]    reg_wdata,
  input  logic [RIDX_W-1:0]   dbg_idx,
  output logic [REG_W-1:0]    dbg_data,
  output logic [PC_W-1:0]     pc,
  output logic [1:0]          state,
  output logic                fire,
  output logic [NUM_REGS-1:0] inc_regs,
  output logic [NUM_REGS-1:0] dec_regs,
  output logic                halted,
  output logic                overflow
);
  import numbotron_pkg::*;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [REG_W-1:0]    r_cnt  [NUM_REGS];
  logic [INSN_W-1:0]   r_prog [PROG_DEPTH];
  logic                r_fire;
  logic [NUM_REGS-1:0] r_inc;
  logic [NUM_REGS-1:0] r_dec;
  logic                r_ovf;

  logic                w_step_pulse;
  logic [31:0]         w_insn32;
  logic [1:0]          w_op;
  logic [RIDX_W-1:0]   w_ridx;
  logic [31:0]         w_tgt_a32;
  logic [31:0]         w_tgt_b32;
  logic [PC_W-1:0]     w_pc_a;
  logic [PC_W-1:0]     w_pc_b;
  logic [REG_W-1:0]    w_cur;
  logic                w_all1;
  logic                w_zero;
  logic [REG_W-1:0]    w_inc_val;
  state_t              w_mode_st;
  logic                w_exec;
  logic                w_edit;

  numbotron_button_edge u_step_edge (
    .clk     (clk),
    .rst     (rstb),
    .i_btn   (step_btn),
    .o_pulse (w_step_pulse)
  );

  always_ff @(posedge clk) begin
    if (prog_we && w_edit) r_prog[prog_addr] <= prog_data;
  end

  assign w_insn32  = 32'(r_prog[r_pc]);
  assign w_op      = 2'(insn_op(w_insn32, RIDX_W, PC_W));
  assign w_ridx    = RIDX_W'(insn_ridx(w_insn32, RIDX_W, PC_W));
  assign w_tgt_a32 = insn_tgt_a(w_insn32, PC_W);
  assign w_tgt_b32 = insn_tgt_b(w_insn32, PC_W);

  // Targets beyond a non-power-of-2 program restart at 0
  assign w_pc_a = (w_tgt_a32 < PROG_DEPTH) ? PC_W'(w_tgt_a32) : '0;
  assign w_pc_b = (w_tgt_b32 < PROG_DEPTH) ? PC_W'(w_tgt_b32) : '0;

  assign w_cur     = r_cnt[w_ridx];
  assign w_all1    = &w_cur;
  assign w_zero    = ~|w_cur;
  assign w_inc_val = w_all1 ? (SATURATE ? w_cur : '0) : w_cur + 1'b1;

  always_comb begin
    w_mode_st = S_EDIT;
    case (mode)
      2'd1:    w_mode_st = S_RUN;
      2'd2:    w_mode_st = S_STEP;
      default: w_mode_st = S_EDIT;
    endcase
  end

  // A pending mode change suppresses execution in the same cycle
  assign w_exec = ((r_state == S_RUN)  && (w_mode_st == S_RUN)  && tick) ||
                  ((r_state == S_STEP) && (w_mode_st == S_STEP) && w_step_pulse);
  assign w_edit = (r_state == S_EDIT);

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_state <= S_EDIT;
      r_pc    <= '0;
      r_fire  <= 1'b0;
      r_inc   <= '0;
      r_dec   <= '0;
      r_ovf   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      r_fire <= w_exec;
      r_inc  <= '0;
      r_dec  <= '0;

      case (r_state)
        S_EDIT, S_RUN, S_STEP: begin
          if (w_mode_st != r_state) r_state <= w_mode_st;
        end
        S_HALT: begin
          if (w_mode_st == S_EDIT) begin
            r_state <= S_EDIT;
            r_pc    <= '0;
          end
        end
      endcase

      if (reg_we && w_edit) r_cnt[reg_widx] <= reg_wdata;

      if (w_exec) begin
        case (w_op)
          OP_INC: begin
            r_cnt[w_ridx] <= w_inc_val;
            r_inc[w_ridx] <= 1'b1;
            if (w_all1) r_ovf <= 1'b1;
            r_pc <= w_pc_a;
          end
          OP_DECJZ: begin
            if (w_zero) begin
              r_pc <= w_pc_b;
            end else begin
              r_cnt[w_ridx] <= w_cur - 1'b1;
              r_dec[w_ridx] <= 1'b1;
              r_pc          <= w_pc_a;
            end
          end
          OP_HALT: r_state <= S_HALT;
          default: r_pc <= w_pc_a;
        endcase
      end
    end
  end

  assign dbg_data = r_cnt[dbg_idx];
  assign pc       = r_pc;
  assign state    = r_state;
  assign fire     = r_fire;
  assign inc_regs = r_inc;
  assign dec_regs = r_dec;
  assign halted   = (r_state == S_HALT);
  assign overflow = r_ovf;

endmodule

// File: tb/tb_numbotron_sequencer.sv
// Directed bench for numbotron_sequencer: single-instruction vector table on a wrapping
// and a saturating instance, plus add-program, step, lockout and async-reset sequences.
module tb_numbotron_sequencer;
  import numbotron_pkg::*;

  logic        clk = 1'b0;
  logic        rstb;
  logic        tick;
  logic        step_btn;
  logic [1:0]  mode;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [14:0] prog_data;
  logic        reg_we;
  logic [2:0]  reg_widx;
  logic [7:0]  reg_wdata;
  logic [2:0]  dbg_idx;

  logic [7:0]  dbg_data,  dbg_data_s;
  logic [4:0]  pc,        pc_s;
  logic [1:0]  state,     state_s;
  logic        fire,      fire_s;
  logic [7:0]  inc_regs,  inc_regs_s;
  logic [7:0]  dec_regs,  dec_regs_s;
  logic        halted,    halted_s;
  logic        overflow,  overflow_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  numbotron_sequencer #(.NUM_REGS(8), .REG_W(8), .PROG_DEPTH(32), .SATURATE(1'b0)) dut (
    .clk(clk), .rstb(rstb), .tick(tick), .step_btn(step_btn), .mode(mode),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_we(reg_we), .reg_widx(reg_widx), .reg_wdata(reg_wdata), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data), .pc(pc), .state(state), .fire(fire), .inc_regs(inc_regs),
    .dec_regs(dec_regs), .halted(halted), .overflow(overflow)
  );

  numbotron_sequencer #(.NUM_REGS(8), .REG_W(8), .PROG_DEPTH(32), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rstb(rstb), .tick(tick), .step_btn(step_btn), .mode(mode),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_we(reg_we), .reg_widx(reg_widx), .reg_wdata(reg_wdata), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data_s), .pc(pc_s), .state(state_s), .fire(fire_s), .inc_regs(inc_regs_s),
    .dec_regs(dec_regs_s), .halted(halted_s), .overflow(overflow_s)
  );

  typedef struct {
    logic [14:0] insn;
    logic [2:0]  ridx;
    logic [7:0]  pre;
    logic [4:0]  e_pc;
    logic [7:0]  e_reg;
    logic [7:0]  e_reg_sat;
    logic [7:0]  e_inc;
    logic [7:0]  e_dec;
    logic        e_halt;
    logic        e_ovf;
  } vec_t;

  vec_t vt[7];

  function automatic logic [14:0] mk(input logic [1:0] op, input logic [2:0] r,
                                     input logic [4:0] a, input logic [4:0] b);
    return {op, r, a, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstb = 1'b1; tick = 1'b0; step_btn = 1'b0; mode = 2'd0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    reg_we = 1'b0; reg_widx = '0; reg_wdata = '0; dbg_idx = '0;
    cyc(); cyc();
    rstb = 1'b0;
    cyc();
  endtask

  task automatic wr_prog(input logic [4:0] a, input logic [14:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] i, input logic [7:0] v);
    reg_we = 1'b1; reg_widx = i; reg_wdata = v;
    cyc();
    reg_we = 1'b0;
  endtask

  task automatic load_add_prog();
    wr_reg(3'd0, 8'd3);
    wr_reg(3'd1, 8'd2);
    wr_prog(5'd0, mk(2'd1, 3'd0, 5'd1, 5'd2));
    wr_prog(5'd1, mk(2'd0, 3'd1, 5'd0, 5'd0));
    wr_prog(5'd2, mk(2'd2, 3'd0, 5'd0, 5'd0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_inc;
    int n_fire;
    int first_fire;

    vt[0] = '{mk(2'd0, 3'd1, 5'd7,  5'd0), 3'd1, 8'd5,   5'd7,  8'd6,   8'd6,   8'h02, 8'h00, 1'b0, 1'b0};
    vt[1] = '{mk(2'd0, 3'd2, 5'd3,  5'd0), 3'd2, 8'd255, 5'd3,  8'd0,   8'd255, 8'h04, 8'h00, 1'b0, 1'b1};
    vt[2] = '{mk(2'd1, 3'd3, 5'd5,  5'd9), 3'd3, 8'd0,   5'd9,  8'd0,   8'd0,   8'h00, 8'h00, 1'b0, 1'b0};
    vt[3] = '{mk(2'd1, 3'd4, 5'd5,  5'd9), 3'd4, 8'd10,  5'd5,  8'd9,   8'd9,   8'h00, 8'h10, 1'b0, 1'b0};
    vt[4] = '{mk(2'd3, 3'd0, 5'd17, 5'd0), 3'd0, 8'd0,   5'd17, 8'd0,   8'd0,   8'h00, 8'h00, 1'b0, 1'b0};
    vt[5] = '{mk(2'd2, 3'd0, 5'd0,  5'd0), 3'd0, 8'd0,   5'd0,  8'd0,   8'd0,   8'h00, 8'h00, 1'b1, 1'b0};
    vt[6] = '{mk(2'd0, 3'd7, 5'd31, 5'd0), 3'd7, 8'd254, 5'd31, 8'd255, 8'd255, 8'h80, 8'h00, 1'b0, 1'b0};

    // Reset state
    do_reset();
    dbg_idx = 3'd5;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_state", 32'(state), 32'(S_EDIT));
    chk("rst_fire", 32'(fire), 32'd0);
    chk("rst_inc", 32'(inc_regs), 32'd0);
    chk("rst_dec", 32'(dec_regs), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_dbg", 32'(dbg_data), 32'd0);

    // Single-instruction vectors
    for (int i = 0; i < 7; i++) begin
      do_reset();
      wr_reg(vt[i].ridx, vt[i].pre);
      wr_prog(5'd0, vt[i].insn);
      dbg_idx = vt[i].ridx;
      mode = 2'd1;
      cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vt[i].e_pc));
      chk($sformatf("v%0d_reg", i), 32'(dbg_data), 32'(vt[i].e_reg));
      chk($sformatf("v%0d_reg_sat", i), 32'(dbg_data_s), 32'(vt[i].e_reg_sat));
      chk($sformatf("v%0d_fire", i), 32'(fire), 32'd1);
      chk($sformatf("v%0d_inc", i), 32'(inc_regs), 32'(vt[i].e_inc));
      chk($sformatf("v%0d_dec", i), 32'(dec_regs), 32'(vt[i].e_dec));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vt[i].e_halt));
      chk($sformatf("v%0d_state", i), 32'(state), vt[i].e_halt ? 32'(S_HALT) : 32'(S_RUN));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vt[i].e_ovf));
      chk($sformatf("v%0d_ovf_sat", i), 32'(overflow_s), 32'(vt[i].e_ovf));
      cyc();
      chk($sformatf("v%0d_fire_pulse", i), 32'(fire), 32'd0);
    end

    // Add program with RUN-state write lockout
    do_reset();
    load_add_prog();
    mode = 2'd1;
    cyc();
    chk("add_state_run", 32'(state), 32'(S_RUN));
    reg_we = 1'b1; reg_widx = 3'd1; reg_wdata = 8'd77;
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = mk(2'd2, 3'd0, 5'd0, 5'd0);
    cyc();
    reg_we = 1'b0; prog_we = 1'b0;
    dbg_idx = 3'd1;
    chk("lock_reg", 32'(dbg_data), 32'd2);
    n_inc = 0;
    for (int t = 1; t <= 8; t++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (inc_regs == 8'h02) n_inc++;
      for (int c = 0; c < 3; c++) begin
        cyc();
        if (inc_regs == 8'h02) n_inc++;
      end
      if (t == 7) chk("add_not_halted_t7", 32'(halted), 32'd0);
    end
    chk("add_halted", 32'(halted), 32'd1);
    chk("add_pc", 32'(pc), 32'd2);
    chk("add_inc_count", 32'(n_inc), 32'd3);
    chk("add_r1", 32'(dbg_data), 32'd5);
    dbg_idx = 3'd0;
    #1;
    chk("add_r0", 32'(dbg_data), 32'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("halt_hold_pc", 32'(pc), 32'd2);
    chk("halt_hold_fire", 32'(fire), 32'd0);

    // HALT -> EDIT clears pc and re-enables writes
    mode = 2'd0;
    cyc();
    chk("edit_pc", 32'(pc), 32'd0);
    chk("edit_state", 32'(state), 32'(S_EDIT));
    dbg_idx = 3'd1;
    wr_reg(3'd1, 8'd99);
    chk("edit_reg", 32'(dbg_data), 32'd99);
    reg_we = 1'b1; reg_widx = 3'd1; reg_wdata = 8'd42;
    #1;
    chk("dbg_old_value", 32'(dbg_data), 32'd99);
    cyc();
    reg_we = 1'b0;
    chk("dbg_new_value", 32'(dbg_data), 32'd42);
    wr_prog(5'd0, mk(2'd0, 3'd1, 5'd0, 5'd0));
    mode = 2'd1;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("edit_prog_exec", 32'(dbg_data), 32'd43);
    chk("edit_prog_inc", 32'(inc_regs), 32'h02);

    // Mode change beats tick, then single step via button
    do_reset();
    load_add_prog();
    mode = 2'd1;
    cyc();
    mode = 2'd2; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("prio_state", 32'(state), 32'(S_STEP));
    chk("prio_fire", 32'(fire), 32'd0);
    chk("prio_pc", 32'(pc), 32'd0);
    n_fire = 0;
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (fire) n_fire++;
      cyc();
      if (fire) n_fire++;
    end
    chk("step_tick_ignored", 32'(n_fire), 32'd0);
    first_fire = -1;
    for (int p = 0; p < 2; p++) begin
      step_btn = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        tick = c[0];
        cyc();
        if (fire) begin
          n_fire++;
          if (p == 0 && first_fire < 0) first_fire = c;
        end
      end
      step_btn = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        tick = c[0];
        cyc();
        if (fire) n_fire++;
      end
    end
    tick = 1'b0;
    chk("step_latency", 32'(first_fire), 32'd4);
    chk("step_fires", 32'(n_fire), 32'd2);
    chk("step_pc", 32'(pc), 32'd0);
    dbg_idx = 3'd0;
    #1;
    chk("step_r0", 32'(dbg_data), 32'd2);
    dbg_idx = 3'd1;
    #1;
    chk("step_r1", 32'(dbg_data), 32'd3);

    // Async reset between clock edges mid-RUN
    do_reset();
    load_add_prog();
    mode = 2'd1;
    cyc();
    for (int t = 0; t < 3; t++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    dbg_idx = 3'd1;
    #1;
    chk("arst_pre_pc", 32'(pc), 32'd1);
    chk("arst_pre_r1", 32'(dbg_data), 32'd3);
    @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_state", 32'(state), 32'(S_EDIT));
    chk("arst_r1", 32'(dbg_data), 32'd0);
    cyc();
    rstb = 1'b0;
    mode = 2'd0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
